// File: rtl/id_imm_skid_stage_pkg.sv
// Shared definitions for the decode-to-execute immediate/skid stage.
//   - Immediate-format select encodings (in_imm_sel).
//   - Skid-buffer occupancy state encoding.
package id_imm_skid_stage_pkg;

  localparam int DATA_W_DEFAULT = 16;

  localparam logic [1:0] IMM_SEL_5    = 2'b00;  // imm = instr[4:0]
  localparam logic [1:0] IMM_SEL_8    = 2'b01;  // imm = instr[7:0]
  localparam logic [1:0] IMM_SEL_11   = 2'b10;  // imm = instr[10:0]
  localparam logic [1:0] IMM_SEL_NONE = 2'b11;  // no immediate, reads as zero

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,  // no entry buffered
    ST_ONE   = 2'b01,  // main register holds the head entry
    ST_FULL  = 2'b10   // main holds head, skid holds the next entry
  } state_e;

endpackage

// File: rtl/id_imm_skid_stage_imm_extend.sv
// Combinational immediate extractor / extender.
// Ports:
//   imm_field  in  11      instr[10:0], the only bits any immediate format uses
//   imm_sel    in  2       immediate format (IMM_SEL_*)
//   sign       in  1       1 = sign-extend, 0 = zero-extend
//   imm        out DATA_W  extended immediate
module imm_extend
  import id_imm_skid_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [10:0]       imm_field,
  input  logic [1:0]        imm_sel,
  input  logic              sign,
  output logic [DATA_W-1:0] imm
);

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    imm = '0;
    case (imm_sel)
      IMM_SEL_5:  imm = {{(DATA_W-5){sign & imm_field[4]}},   imm_field[4:0]};
      IMM_SEL_8:  imm = {{(DATA_W-8){sign & imm_field[7]}},   imm_field[7:0]};
      IMM_SEL_11: imm = {{(DATA_W-11){sign & imm_field[10]}}, imm_field[10:0]};
      default:    imm = '0;  // IMM_SEL_NONE
    endcase
  end

endmodule

// File: rtl/id_imm_skid_stage.sv
// Decode-to-execute boundary stage. Extends the instruction's immediate on
// the way in and holds entries in a 2-entry skid buffer (main + skid) so that
// in_ready is a flop and never depends combinationally on out_ready.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               decode-side handshake (in_ready registered)
//   in_instr, in_pc                 instruction word and its PC+2
//   in_imm_sel, in_sign             immediate format and extension mode
//   flush                           drop everything buffered and incoming
//   out_valid/out_ready             execute-side handshake (out_valid registered)
//   out_instr, out_pc, out_imm      head entry, driven straight from main reg
module id_imm_skid_stage
  import id_imm_skid_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [1:0]        in_imm_sel,
  input  logic              in_sign,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_imm
);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm;
  } entry_t;

  state_e            state;
  entry_t            main_q;
  entry_t            skid_q;
  entry_t            in_entry;
  logic [DATA_W-1:0] in_imm;
  logic              accept;
  logic              pop;

  imm_extend #(.DATA_W(DATA_W)) u_imm_extend (
    .imm_field (in_instr[10:0]),
    .imm_sel   (in_imm_sel),
    .sign      (in_sign),
    .imm       (in_imm)
  );

  assign in_entry = '{instr: in_instr, pc: in_pc, imm: in_imm};
  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  assign out_instr = main_q.instr;
  assign out_pc    = main_q.pc;
  assign out_imm   = main_q.imm;

  // out_valid and in_ready are registered alongside the state so they are
  // pure flop outputs: out_valid == (state != EMPTY), in_ready == (state != FULL).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two data registers are cleared on reset so out_* read as
      // zero straight out of reset; they are small enough that this is cheap.
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      main_q    <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      // Flush wins over everything: concurrent accept and pop are discarded.
      // Data registers keep stale contents; out_valid is what matters.
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_q    <= in_entry;
            state     <= ST_ONE;
            out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !pop) begin
            skid_q   <= in_entry;
            state    <= ST_FULL;
            in_ready <= 1'b0;
          end else if (accept && pop) begin
            main_q <= in_entry;
          end else if (pop) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low, so nothing can be accepted here.
          if (pop) begin
            main_q   <= skid_q;
            state    <= ST_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
